bo_datapath: RTL and testbench
==============================

Name: bo_datapath

Overview:
- Operational block (datapath) driven by the 4-bit control FSM: consumes its select and load strobes (m0, m1, m2, lx, ls, lh, h, done) and holds the working registers X, S and H.
- Provides a registered result with a valid/ready output handshake, plus sticky overflow/overrun flags.
- Sits between the control FSM and the consumer of the computed value; the FSM's start input w is also wired here as start.

Parameters:
- WIDTH, 8, data width of X, S, H, ALU and result.
- KCONST, 3, constant operand selectable on mux A.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  same pulse as the FSM start (w); clears the flags.
- data_in  in  WIDTH  external operand.
- m0  in  2  mux A select.
- m1  in  2  mux B select.
- m2  in  2  ALU op select.
- lx  in  1  load X.
- ls  in  1  load S.
- lh  in  1  load H.
- h  in  1  H source select.
- done  in  1  capture result.
- result  out  WIDTH  captured result.
- result_valid  out  1  result holds unconsumed data.
- result_ready  in  1  consumer accepts result.
- ovf  out  1  sticky arithmetic overflow.
- overrun  out  1  sticky: unconsumed result was overwritten.
- alu_out  out  WIDTH  combinational ALU output (debug/observe).

Behaviour:
- All state updates on posedge clk. rst=1 has priority over every other input: X, S, H, result = 0; result_valid, ovf, overrun = 0.
- Mux A (m0): 00 X, 01 S, 10 H, 11 KCONST.
- Mux B (m1): 00 X, 01 S, 10 H, 11 data_in.
- ALU (m2), computed at WIDTH+1 bits internally, output truncated to WIDTH bits:
  - 00 A+B; carry out = overflow event.
  - 01 A-B; borrow (A<B) = overflow event.
  - 10 low WIDTH bits of A*B; nonzero high half = overflow event.
  - 11 pass A; never an overflow event.
- Register loads (no latency beyond one edge; loads in the same cycle are independent):
  - lx=1: X <= data_in.
  - ls=1: S <= alu_out.
  - lh=1: H <= alu_out when h=0, H <= data_in when h=1.
  - Unloaded registers hold their value.
- ALU operands are the pre-edge register values. A register loaded and read in the same cycle supplies its old value.
- ovf:
  - Set on any edge where ls=1 or lh=1 (with h=0) and the current ALU op raises an overflow event.
  - Cleared by start=1. If start and a set condition occur in the same cycle, start wins (flag = 0).
- done=1: result <= next value of S (alu_out if ls=1 that cycle, else current S); result_valid <= 1.
- Output handshake:
  - A transfer occurs when result_valid=1 and result_ready=1 on an edge.
  - Transfer without done: result_valid <= 0.
  - Transfer with done: the new result is loaded, result_valid stays 1, no overrun.
  - done while result_valid=1 and result_ready=0: result is overwritten, overrun <= 1.
  - result and result_valid are unaffected by start. overrun is cleared only by start or rst.
- No internal state machine beyond the handshake valid bit. Control sequencing belongs to the FSM; the datapath never gates illegal control combinations.

Decomposition:
- Shared package bo_pkg:
  - select encodings: SEL_X, SEL_S, SEL_H, SEL_K/SEL_IN.
  - ALU op codes: OP_ADD, OP_SUB, OP_MUL, OP_PASS.
  - WIDTH default.
- One natural sub-module: bo_alu. Purely combinational; inputs a, b, op; outputs y, ovf_evt.
- Registers, muxes and the handshake stay in bo_datapath.

Test Plan:
All scenarios use WIDTH=8, KCONST=3.
1. rst=1 for 2 cycles with all strobes high -> X=S=H=result=0, result_valid=ovf=overrun=0.
2. data_in=5, lx=1 for one cycle; then m0=00, m1=11, m2=00, data_in=7, ls=1 -> S=12; then done=1 -> result=12, result_valid=1; result_ready=1 one cycle -> result_valid=0.
3. S=200, X=100, m0=01, m1=00, m2=00, ls=1 -> S=44, ovf=1; next cycle start=1 -> ovf=0, S stays 44.
4. X=4, m0=11, m1=00, m2=10, lh=1, h=0 -> H=12, ovf=0; then X=100 same op -> H=44 (300 mod 256), ovf=1.
5. done with result_ready=0 twice (S=9, then S=10) -> result=10, result_valid=1, overrun=1; done together with result_ready=1 -> new value, result_valid=1, overrun unchanged.
6. ls=1 and done=1 in the same cycle with alu_out=33, S=20 -> S=33 and result=33. Then assert rst during result_valid=1 -> all cleared on that edge.

Source files
------------

// File: rtl/bo_pkg.sv
// Shared encodings for the operational block: mux selects, ALU op codes and default width.
package bo_pkg;

    localparam int BO_WIDTH = 8;

    localparam logic [1:0] SEL_X  = 2'b00;
    localparam logic [1:0] SEL_S  = 2'b01;
    localparam logic [1:0] SEL_H  = 2'b10;
    localparam logic [1:0] SEL_K  = 2'b11;
    localparam logic [1:0] SEL_IN = 2'b11;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_PASS = 2'b11
    } alu_op_e;

endpackage

// File: rtl/bo_alu.sv
// Combinational ALU: add/sub/mul/pass with an overflow event (carry, borrow or
// nonzero product high half).
module bo_alu
    import bo_pkg::*;
#(
    parameter int WIDTH = BO_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] y,
    output logic             ovf_evt
);

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic [2*WIDTH-1:0] w_prod;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    // The extra bit of the difference is the borrow, i.e. a < b.
    assign w_dif  = {1'b0, a} - {1'b0, b};
    assign w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    always_comb begin
        y       = a;
        ovf_evt = 1'b0;
        case (op)
            OP_ADD: begin
                y       = w_sum[WIDTH-1:0];
                ovf_evt = w_sum[WIDTH];
            end
            OP_SUB: begin
                y       = w_dif[WIDTH-1:0];
                ovf_evt = w_dif[WIDTH];
            end
            OP_MUL: begin
                y       = w_prod[WIDTH-1:0];
                ovf_evt = |w_prod[2*WIDTH-1:WIDTH];
            end
            default: begin
                y       = a;
                ovf_evt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/bo_datapath.sv
// Operational block: working registers X/S/H, operand muxes, ALU, sticky flags and
// a registered result with a valid/ready output handshake.
module bo_datapath
    import bo_pkg::*;
#(
    parameter int WIDTH  = BO_WIDTH,
    parameter int KCONST = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       m0,
    input  logic [1:0]       m1,
    input  logic [1:0]       m2,
    input  logic             lx,
    input  logic             ls,
    input  logic             lh,
    input  logic             h,
    input  logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             ovf,
    output logic             overrun,
    output logic [WIDTH-1:0] alu_out
);

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_h;
    logic [WIDTH-1:0] r_result;
    logic             r_valid;
    logic             r_ovf;
    logic             r_overrun;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_y;
    logic             w_evt;
    logic [WIDTH-1:0] w_s_next;
    logic             w_ovf_set;
    logic             w_xfer;
    logic             w_overwrite;

    always_comb begin
        w_a = WIDTH'(KCONST);
        case (m0)
            SEL_X:   w_a = r_x;
            SEL_S:   w_a = r_s;
            SEL_H:   w_a = r_h;
            default: w_a = WIDTH'(KCONST);
        endcase
    end

    always_comb begin
        w_b = data_in;
        case (m1)
            SEL_X:   w_b = r_x;
            SEL_S:   w_b = r_s;
            SEL_H:   w_b = r_h;
            default: w_b = data_in;
        endcase
    end

    bo_alu #(.WIDTH(WIDTH)) u_alu (
        .a       (w_a),
        .b       (w_b),
        .op      (alu_op_e'(m2)),
        .y       (w_y),
        .ovf_evt (w_evt)
    );

    // Handshake: the result transfers on any edge where result_valid and
    // result_ready are both high; valid then drops unless done reloads it.
    assign w_s_next    = ls ? w_y : r_s;
    assign w_ovf_set   = w_evt & (ls | (lh & ~h));
    assign w_xfer      = r_valid & result_ready;
    assign w_overwrite = done & r_valid & ~result_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x       <= '0;
            r_s       <= '0;
            r_h       <= '0;
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (lx) r_x <= data_in;
            r_s <= w_s_next;
            if (lh) r_h <= h ? data_in : w_y;

            if (start)          r_ovf <= 1'b0;
            else if (w_ovf_set) r_ovf <= 1'b1;

            if (done) begin
                r_result <= w_s_next;
                r_valid  <= 1'b1;
            end else if (w_xfer) begin
                r_valid  <= 1'b0;
            end

            if (start)            r_overrun <= 1'b0;
            else if (w_overwrite) r_overrun <= 1'b1;
        end
    end

    assign result       = r_result;
    assign result_valid = r_valid;
    assign ovf          = r_ovf;
    assign overrun      = r_overrun;
    assign alu_out      = w_y;

endmodule

// File: tb/tb_bo_datapath.sv
// Bench for bo_datapath: reference model with a result scoreboard queue, a vector
// table of ALU cases, hand-written handshake sequences and a random phase.
module tb_bo_datapath;

  localparam logic [1:0] A_X = 2'b00, A_S = 2'b01, A_H = 2'b10, A_K = 2'b11;
  localparam logic [1:0] B_IN = 2'b11;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, PASS = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic [1:0] m0, m1, m2;
  logic       lx, ls, lh, h, done;
  logic [7:0] result;
  logic       result_valid;
  logic       result_ready;
  logic       ovf, overrun;
  logic [7:0] alu_out;

  typedef struct packed {
    logic [1:0] m0, m1, m2;
    logic [7:0] din;
    logic lx, ls, lh, h, done, rdy, st;
  } ctl_t;

  typedef struct packed {
    ctl_t       c;
    logic [7:0] exp_y;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_x, m_s, m_h;
  logic m_valid, m_ovf, m_ovr;
  vec_t vecs[10];

  bo_datapath #(.WIDTH(8), .KCONST(3)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .m0(m0), .m1(m1), .m2(m2), .lx(lx), .ls(ls), .lh(lh), .h(h), .done(done),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .ovf(ovf), .overrun(overrun), .alu_out(alu_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic ctl_t mk(logic [1:0] a, logic [1:0] b, logic [1:0] op, logic [7:0] din,
                              logic vlx, logic vls, logic vlh, logic vh, logic vdone,
                              logic vrdy, logic vst);
    ctl_t c;
    c.m0 = a; c.m1 = b; c.m2 = op; c.din = din;
    c.lx = vlx; c.ls = vls; c.lh = vlh; c.h = vh; c.done = vdone; c.rdy = vrdy; c.st = vst;
    return c;
  endfunction

  function automatic logic [8:0] ref_alu(logic [7:0] a, logic [7:0] b, logic [1:0] op);
    logic [15:0] p;
    case (op)
      ADD:     return 9'(a) + 9'(b);
      SUB:     return {a < b, 8'(a - b)};
      MUL:     begin p = 16'(a) * 16'(b); return {|p[15:8], p[7:0]}; end
      default: return {1'b0, a};
    endcase
  endfunction

  function automatic logic [7:0] mux_val(logic [1:0] sel, logic [7:0] last);
    case (sel)
      A_X:     return m_x;
      A_S:     return m_s;
      A_H:     return m_h;
      default: return last;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic apply(input ctl_t c);
    m0 = c.m0; m1 = c.m1; m2 = c.m2; data_in = c.din;
    lx = c.lx; ls = c.ls; lh = c.lh; h = c.h; done = c.done;
    result_ready = c.rdy; start = c.st;
  endtask

  task automatic cycle(input ctl_t c, input logic chk_y, input logic [7:0] exp_y);
    logic [8:0] r;
    logic [7:0] a, b, val, nx, ns, nh;
    logic       nvalid, ovr_set;
    apply(c);
    #1;
    a = mux_val(c.m0, 8'd3);
    b = mux_val(c.m1, c.din);
    r = ref_alu(a, b, c.m2);
    check("alu_out", alu_out, r[7:0]);
    if (chk_y) check("vec_alu_out", alu_out, exp_y);
    if (m_valid && c.rdy) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underflow: transfer with result=%0d but no expected entry", result);
      end else begin
        check("sb_result", result, exp_q.pop_front());
      end
    end
    nx = c.lx ? c.din : m_x;
    ns = c.ls ? r[7:0] : m_s;
    nh = c.lh ? (c.h ? c.din : r[7:0]) : m_h;
    if (c.st) m_ovf = 1'b0;
    else if (r[8] && (c.ls || (c.lh && !c.h))) m_ovf = 1'b1;
    nvalid = m_valid;
    ovr_set = 1'b0;
    if (c.done) begin
      val = c.ls ? r[7:0] : m_s;
      if (m_valid && !c.rdy) begin
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        ovr_set = 1'b1;
      end
      exp_q.push_back(val);
      nvalid = 1'b1;
    end else if (m_valid && c.rdy) begin
      nvalid = 1'b0;
    end
    if (c.st) m_ovr = 1'b0;
    else if (ovr_set) m_ovr = 1'b1;
    m_x = nx; m_s = ns; m_h = nh; m_valid = nvalid;
    @(posedge clk);
    #1;
    check("ovf", ovf, m_ovf);
    check("overrun", overrun, m_ovr);
    check("result_valid", result_valid, m_valid);
    if (m_valid && exp_q.size() > 0) check("result_hold", result, exp_q[$]);
  endtask

  task automatic peek(input logic [1:0] sel, input logic [7:0] exp, input string name);
    apply(mk(sel, A_X, PASS, 8'd0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check(name, alu_out, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(mk(2'b11, 2'b11, 2'b11, 8'hff, 1, 1, 1, 1, 1, 1, 1));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_x = 0; m_s = 0; m_h = 0; m_valid = 0; m_ovf = 0; m_ovr = 0;
    exp_q.delete();
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_overrun", overrun, 0);
    peek(A_X, 8'd0, "rst_x");
    peek(A_S, 8'd0, "rst_s");
    peek(A_H, 8'd0, "rst_h");
  endtask

  initial begin
    rst = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    do_reset();

    // load X, add data_in into S, capture, consume
    cycle(mk(A_X, A_X, PASS, 8'd5, 1, 0, 0, 0, 0, 0, 0), 0, 0);
    cycle(mk(A_X, B_IN, ADD, 8'd7, 0, 1, 0, 0, 0, 0, 0), 1, 8'd12);
    peek(A_S, 8'd12, "t2_s");
    cycle(mk(A_X, A_X, PASS, 8'd0, 0, 0, 0, 0, 1, 0, 0), 0, 0);
    check("t2_result", result, 12);
    check("t2_valid", result_valid, 1);
    cycle(mk(A_X, A_X, PASS, 8'd0, 0, 0, 0, 0, 0, 1, 0), 0, 0);
    check("t2_valid_drop", result_valid, 0);

    // carry overflow into S, cleared by start
    cycle(mk(A_X, A_X, PASS, 8'd0, 1, 0, 0, 0, 0, 0, 0), 0, 0);
    cycle(mk(A_X, B_IN, ADD, 8'd200, 0, 1, 0, 0, 0, 0, 0), 0, 0);
    cycle(mk(A_X, A_X, PASS, 8'd100, 1, 0, 0, 0, 0, 0, 0), 0, 0);
    cycle(mk(A_S, A_X, ADD, 8'd0, 0, 1, 0, 0, 0, 0, 0), 1, 8'd44);
    check("t3_ovf_set", ovf, 1);
    cycle(mk(A_X, A_X, PASS, 8'd0, 0, 0, 0, 0, 0, 0, 1), 0, 0);
    check("t3_ovf_clr", ovf, 0);
    peek(A_S, 8'd44, "t3_s");

    // K*X into H: in range, then multiply overflow
    cycle(mk(A_X, A_X, PASS, 8'd4, 1, 0, 0, 0, 0, 0, 0), 0, 0);
    cycle(mk(A_K, A_X, MUL, 8'd0, 0, 0, 1, 0, 0, 0, 0), 1, 8'd12);
    check("t4_ovf_low", ovf, 0);
    peek(A_H, 8'd12, "t4_h12");
    cycle(mk(A_X, A_X, PASS, 8'd100, 1, 0, 0, 0, 0, 0, 0), 0, 0);
    cycle(mk(A_K, A_X, MUL, 8'd0, 0, 0, 1, 0, 0, 0, 0), 1, 8'd44);
    check("t4_ovf_high", ovf, 1);
    peek(A_H, 8'd44, "t4_h44");

    // overrun: two captures without ready, then capture with ready
    cycle(mk(A_X, A_X, PASS, 8'd0, 0, 0, 0, 0, 0, 0, 1), 0, 0);
    cycle(mk(A_K, B_IN, ADD, 8'd6, 0, 1, 0, 0, 0, 0, 0), 1, 8'd9);
    cycle(mk(A_X, A_X, PASS, 8'd0, 0, 0, 0, 0, 1, 0, 0), 0, 0);
    cycle(mk(A_K, B_IN, ADD, 8'd7, 0, 1, 0, 0, 0, 0, 0), 1, 8'd10);
    cycle(mk(A_X, A_X, PASS, 8'd0, 0, 0, 0, 0, 1, 0, 0), 0, 0);
    check("t5_result", result, 10);
    check("t5_overrun", overrun, 1);
    cycle(mk(A_K, B_IN, ADD, 8'd8, 0, 1, 0, 0, 0, 0, 0), 1, 8'd11);
    cycle(mk(A_X, A_X, PASS, 8'd0, 0, 0, 0, 0, 1, 1, 0), 0, 0);
    check("t5_result_new", result, 11);
    check("t5_valid_kept", result_valid, 1);
    check("t5_overrun_kept", overrun, 1);
    cycle(mk(A_X, A_X, PASS, 8'd0, 0, 0, 0, 0, 0, 1, 0), 0, 0);

    // ls and done together capture the new S; reset while valid
    cycle(mk(A_K, B_IN, ADD, 8'd17, 0, 1, 0, 0, 0, 0, 0), 1, 8'd20);
    cycle(mk(A_S, B_IN, ADD, 8'd13, 0, 1, 0, 0, 1, 0, 0), 1, 8'd33);
    check("t6_result", result, 33);
    peek(A_S, 8'd33, "t6_s");
    do_reset();

    // vector table over X=100, S=200, H=12
    cycle(mk(A_X, A_X, PASS, 8'd100, 1, 0, 0, 0, 0, 0, 0), 0, 0);
    cycle(mk(A_X, A_X, ADD, 8'd0, 0, 1, 0, 0, 0, 0, 0), 1, 8'd200);
    cycle(mk(A_X, A_X, PASS, 8'd12, 0, 0, 1, 1, 0, 0, 1), 0, 0);
    vecs[0] = '{mk(A_X, A_S, ADD, 8'd0, 0, 0, 0, 0, 0, 0, 0), 8'd44};
    vecs[1] = '{mk(A_S, A_X, SUB, 8'd0, 0, 0, 0, 0, 0, 0, 0), 8'd100};
    vecs[2] = '{mk(A_X, A_S, SUB, 8'd0, 0, 0, 0, 0, 0, 0, 0), 8'd156};
    vecs[3] = '{mk(A_H, B_IN, MUL, 8'd5, 0, 0, 0, 0, 0, 0, 0), 8'd60};
    vecs[4] = '{mk(A_K, A_H, MUL, 8'd0, 0, 0, 0, 0, 0, 0, 0), 8'd36};
    vecs[5] = '{mk(A_S, A_H, MUL, 8'd0, 0, 0, 0, 0, 0, 0, 0), 8'd96};
    vecs[6] = '{mk(A_H, A_S, PASS, 8'd0, 0, 0, 0, 0, 0, 0, 0), 8'd12};
    vecs[7] = '{mk(A_K, A_X, PASS, 8'd0, 0, 0, 0, 0, 0, 0, 0), 8'd3};
    vecs[8] = '{mk(A_X, B_IN, ADD, 8'd255, 0, 0, 0, 0, 0, 0, 0), 8'd99};
    vecs[9] = '{mk(A_K, B_IN, SUB, 8'd3, 0, 0, 0, 0, 0, 0, 0), 8'd0};
    for (int i = 0; i < 10; i++) cycle(vecs[i].c, 1, vecs[i].exp_y);

    // random control mix against the model
    for (int i = 0; i < 60; i++) begin
      cycle(mk(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0)), 0, 0);
    end
    cycle(mk(A_X, A_X, PASS, 8'd0, 0, 0, 0, 0, 0, 1, 0), 0, 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
